// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - width codes, FSM states and command type for the data-memory arbiter
package mem_arb_pkg;

  // funct3-style access width codes
  localparam logic [2:0] MW_B  = 3'b000;
  localparam logic [2:0] MW_H  = 3'b001;
  localparam logic [2:0] MW_W  = 3'b010;
  localparam logic [2:0] MW_BU = 3'b100;
  localparam logic [2:0] MW_HU = 3'b101;

  // Arbiter sequencing: wait for a request, then spend one cycle on the memory
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  // One accepted memory command
  typedef struct packed {
    logic        we;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_align_check.sv
// rtl/mem_align_check.sv - width/address legality check shared by the arbiter and the core LSU
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic [2:0] width,
  input  logic [1:0] addr_lo,
  output logic       aligned
);

  // Each legal width needs its natural alignment; unknown width codes are never legal
  always_comb begin
    aligned = 1'b0;
    case (width)
      MW_B, MW_BU: aligned = 1'b1;
      MW_H, MW_HU: aligned = ~addr_lo[0];
      MW_W:        aligned = (addr_lo == 2'b00);
      default:     aligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-cycle data memory
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [2:0]  req0_width,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [2:0]  req1_width,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic        mem_we,
  output logic [2:0]  mem_width,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_t  state;
  mem_cmd_t    cmd;
  mem_cmd_t    new_cmd;
  logic        cmd_port;
  logic        rr;
  logic        aligned;
  logic        any_valid;
  logic        grant_port;
  logic        accept;
  logic [31:0] load_data;

  mem_align_check u_align (
    .width   (cmd.width),
    .addr_lo (cmd.addr[1:0]),
    .aligned (aligned)
  );

  // Winner selection: the preferred port when both ask, otherwise whoever is asking
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_port = rr;
    end else begin
      grant_port = req1_valid;
    end
  end

  // Ready goes only to the winner, only in IDLE and never while reset is held
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && (state == IDLE) && any_valid) begin
      req0_ready = ~grant_port;
      req1_ready = grant_port;
    end
  end

  assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Command of the winning port, ready to be latched on acceptance
  always_comb begin
    new_cmd = '0;
    if (grant_port) begin
      new_cmd.we    = req1_we;
      new_cmd.width = req1_width;
      new_cmd.addr  = req1_addr;
      new_cmd.wdata = req1_wdata;
    end else begin
      new_cmd.we    = req0_we;
      new_cmd.width = req0_width;
      new_cmd.addr  = req0_addr;
      new_cmd.wdata = req0_wdata;
    end
  end

  // Memory side is driven from the latch; the write strobe only exists during ACCESS
  always_comb begin
    mem_we    = (state == ACCESS) & cmd.we & aligned;
    mem_width = cmd.width;
    mem_addr  = cmd.addr;
    mem_wdata = cmd.wdata;
  end

  // Only aligned loads return memory data; stores and rejected accesses return zero
  assign load_data = (aligned && !cmd.we) ? mem_rdata : 32'h0;

  // Sequencing: accept in IDLE, spend exactly one cycle in ACCESS, rotate the preference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 1'b0;
      cmd      <= '0;
      cmd_port <= 1'b0;
    end else if (state == ACCESS) begin
      state <= IDLE;
    end else if (accept) begin
      state    <= ACCESS;
      cmd      <= new_cmd;
      cmd_port <= grant_port;
      rr       <= ~grant_port;
    end
  end

  // Response pulse to the latched port as ACCESS ends; reset drops any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= 32'h0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= 32'h0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= 32'h0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= 32'h0;
      rsp1_err   <= 1'b0;
      if (state == ACCESS) begin
        if (cmd_port) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= load_data;
          rsp1_err   <= ~aligned;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= load_data;
          rsp0_err   <= ~aligned;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  v = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [2:0]  wd  [2];
  logic [31:0] ad  [2];
  logic [31:0] wdt [2];

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_we;
  logic [2:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [1:0]  rdy, rv, re;
  logic [31:0] rrd [2];
  assign rdy    = {req1_ready, req0_ready};
  assign rv     = {rsp1_valid, rsp0_valid};
  assign re     = {rsp1_err, rsp0_err};
  assign rrd[0] = rsp0_rdata;
  assign rrd[1] = rsp1_rdata;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (v[0]),
    .req0_ready (req0_ready),
    .req0_we    (we[0]),
    .req0_width (wd[0]),
    .req0_addr  (ad[0]),
    .req0_wdata (wdt[0]),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .req1_valid (v[1]),
    .req1_ready (req1_ready),
    .req1_we    (we[1]),
    .req1_width (wd[1]),
    .req1_addr  (ad[1]),
    .req1_wdata (wdt[1]),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .mem_we     (mem_we),
    .mem_width  (mem_width),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory seen by the DUT: byte array, combinational extended read, write on clock
  logic [7:0] mem [0:1023] = '{default: 8'h00};
  logic [9:0] ma;
  assign ma = mem_addr[9:0];

  always_comb begin
    case (mem_width)
      3'b000:  mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
      3'b001:  mem_rdata = {{16{mem[ma+10'd1][7]}}, mem[ma+10'd1], mem[ma]};
      3'b100:  mem_rdata = {24'h0, mem[ma]};
      3'b101:  mem_rdata = {16'h0, mem[ma+10'd1], mem[ma]};
      default: mem_rdata = {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_width[1:0] != 2'b00) mem[ma+10'd1] <= mem_wdata[15:8];
      if (mem_width[1]) begin
        mem[ma+10'd2] <= mem_wdata[23:16];
        mem[ma+10'd3] <= mem_wdata[31:24];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: byte image plus legality and load rules written as arithmetic
  int unsigned ref_mem [0:1023] = '{default: 0};

  function automatic bit legal(input logic [2:0] w, input logic [31:0] a);
    case (w)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] w, input logic [31:0] a);
    int unsigned b0, b1, u;
    b0 = ref_mem[a % 1024];
    b1 = ref_mem[(a + 1) % 1024];
    case (w)
      3'd0: return (b0 >= 128) ? b0 - 256 : b0;
      3'd1: begin u = b0 + 256 * b1; return (u >= 32768) ? u - 65536 : u; end
      3'd4: return b0;
      3'd5: return b0 + 256 * b1;
      default: return b0 + 256 * b1 + 65536 * ref_mem[(a + 2) % 1024]
                      + 16777216 * ref_mem[(a + 3) % 1024];
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = ((w % 4) == 0) ? 1 : ((w % 4) == 1) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[(a + i) % 1024] = (d >> (8 * i)) % 256;
  endtask

  // Model + compare: each cycle predict ready, memory side and responses, then advance
  initial begin
    int pref, win, m_port, m_rport;
    bit m_acc, m_rsp, m_rerr;
    logic m_we;
    logic [2:0] m_w;
    logic [31:0] m_a, m_d, m_rdata;
    pref = 0; m_acc = 0; m_rsp = 0; m_port = 0; m_rport = 0; m_rerr = 0;
    m_we = 0; m_w = 0; m_a = 0; m_d = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_ready", {30'b0, rdy}, 0);
        check("rst_rsp_valid", {30'b0, rv}, 0);
        check("rst_mem_we", {31'b0, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_width", {29'b0, mem_width}, 0);
        pref = 0; m_acc = 0; m_rsp = 0;
        m_we = 0; m_w = 0; m_a = 0; m_d = 0;
      end else begin
        win = -1;
        if (!m_acc) begin
          if (v[0] && v[1]) win = pref;
          else if (v[0]) win = 0;
          else if (v[1]) win = 1;
        end
        for (int p = 0; p < 2; p++) begin
          check($sformatf("ready%0d", p), {31'b0, rdy[p]}, {31'b0, win == p});
          check($sformatf("rsp%0d_valid", p), {31'b0, rv[p]}, {31'b0, m_rsp && m_rport == p});
          if (m_rsp && m_rport == p) begin
            check($sformatf("rsp%0d_rdata", p), rrd[p], m_rdata);
            check($sformatf("rsp%0d_err", p), {31'b0, re[p]}, {31'b0, m_rerr});
          end
        end
        check("mem_we", {31'b0, mem_we}, {31'b0, m_acc && m_we && legal(m_w, m_a)});
        check("mem_addr", mem_addr, m_a);
        check("mem_width", {29'b0, mem_width}, {29'b0, m_w});
        check("mem_wdata", mem_wdata, m_d);
        m_rsp = m_acc;
        if (m_acc) begin
          m_rport = m_port;
          m_rerr  = !legal(m_w, m_a);
          m_rdata = (!m_rerr && !m_we) ? ref_load(m_w, m_a) : 32'h0;
          if (!m_rerr && m_we) ref_store(m_w, m_a, m_d);
        end
        m_acc = 0;
        if (win >= 0) begin
          m_acc = 1; m_port = win; pref = 1 - win;
          m_we = we[win]; m_w = wd[win]; m_a = ad[win]; m_d = wdt[win];
        end
      end
    end
  end

  // Issue one request on port p and collect its response; returns at posedge+1
  task automatic do_req(input int p, input logic w_e, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
    bit got;
    got = 0; rd = '0; er = 1'b0; lat = -1;
    we[p] = w_e; wd[p] = w; ad[p] = a; wdt[p] = d; v[p] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rdy[p];
    end
    @(posedge clk); #1;
    v[p] = 1'b0;
    if (!got) begin
      fail_now($sformatf("accept_timeout port%0d", p));
      return;
    end
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (rv[p]) begin lat = k; rd = rrd[p]; er = re[p]; end
    end
    if (lat < 0) fail_now($sformatf("rsp_timeout port%0d", p));
    @(posedge clk); #1;
  endtask

  // Random traffic on one port: gaps, back-to-back requests and occasional withdrawals
  task automatic rand_port(input int p, input int n);
    bit acc;
    logic [2:0] w;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        v[p] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      w = 3'($urandom_range(0, 7));
      if ((w == 3'd3 || w >= 3'd6) && $urandom_range(0, 3) != 0) w = 3'd2;
      a = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      we[p] = 1'($urandom_range(0, 1)); wd[p] = w; ad[p] = a; wdt[p] = $urandom; v[p] = 1'b1;
      acc = 0;
      for (int k = 0; k < 20 && !acc; k++) begin
        @(negedge clk);
        acc = rdy[p];
        @(posedge clk); #1;
        if (!acc && $urandom_range(0, 15) == 0) break;
      end
      if (!acc) begin
        v[p] = 1'b0;
        @(posedge clk); #1;
      end
    end
    v[p] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, both;
    bit got;
    int grants[$];
    int r0[$];
    int r1[$];
    for (int p = 0; p < 2; p++) begin wd[p] = 3'd2; ad[p] = 32'h40; wdt[p] = 32'h0; end

    // Reset with a request pending: ready must stay low
    v = 2'b01;
    repeat (3) @(negedge clk);
    check("reset_ready0_gated", {31'b0, req0_ready}, 0);
    check("reset_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; v = 2'b00;
    @(posedge clk); #1;

    // Word store then load on port 0
    do_req(0, 1'b1, 3'd2, 32'h40, 32'h1234_5678, rd, er, lat);
    check("w_store_err", {31'b0, er}, 0);
    check("w_store_latency", lat, 2);
    do_req(0, 1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat);
    check("w_load_rdata", rd, 32'h1234_5678);
    check("w_load_err", {31'b0, er}, 0);
    check("w_load_latency", lat, 2);

    // Byte stores by port 1 assembled by a word load on port 0
    do_req(1, 1'b1, 3'd0, 32'h80, 32'h89, rd, er, lat);
    do_req(1, 1'b1, 3'd0, 32'h81, 32'h67, rd, er, lat);
    do_req(1, 1'b1, 3'd0, 32'h82, 32'h45, rd, er, lat);
    do_req(1, 1'b1, 3'd0, 32'h83, 32'h23, rd, er, lat);
    do_req(0, 1'b0, 3'd2, 32'h80, 32'h0, rd, er, lat);
    check("byte_assemble", rd, 32'h2345_6789);

    // Illegal accesses are rejected and leave memory untouched
    do_req(0, 1'b1, 3'd1, 32'h41, 32'hAAAA_AAAA, rd, er, lat);
    check("h_mis_err", {31'b0, er}, 1);
    check("h_mis_rdata", rd, 0);
    do_req(1, 1'b1, 3'd2, 32'h42, 32'hBBBB_BBBB, rd, er, lat);
    check("w_mis_err", {31'b0, er}, 1);
    check("w_mis_rdata", rd, 0);
    do_req(0, 1'b1, 3'd3, 32'h40, 32'hCCCC_CCCC, rd, er, lat);
    check("w011_err", {31'b0, er}, 1);
    check("w011_latency", lat, 2);
    do_req(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat);
    check("illegal_readback", rd, 32'h1234_5678);

    // Sign and zero extension
    do_req(0, 1'b1, 3'd2, 32'h10, 32'hF0F0_F0F0, rd, er, lat);
    do_req(0, 1'b0, 3'd0, 32'h10, 32'h0, rd, er, lat);
    check("load_b", rd, 32'hFFFF_FFF0);
    do_req(1, 1'b0, 3'd1, 32'h10, 32'h0, rd, er, lat);
    check("load_h", rd, 32'hFFFF_F0F0);
    do_req(0, 1'b0, 3'd4, 32'h10, 32'h0, rd, er, lat);
    check("load_bu", rd, 32'h0000_00F0);
    do_req(1, 1'b0, 3'd5, 32'h10, 32'h0, rd, er, lat);
    check("load_hu", rd, 32'h0000_F0F0);

    // Both ports continuously valid straight out of reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    we = 2'b00; wd[0] = 3'd2; ad[0] = 32'h80; wd[1] = 3'd2; ad[1] = 32'h40;
    v = 2'b11;
    both = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rdy[0] && rdy[1]) both++;
      if (rdy[0]) grants.push_back(0);
      else if (rdy[1]) grants.push_back(1);
      if (rv[0]) r0.push_back(c);
      if (rv[1]) r1.push_back(c);
    end
    @(posedge clk); #1;
    v = 2'b00;
    check("rr_both_ready", both, 0);
    check("rr_grant_count", grants.size(), 8);
    if (grants.size() >= 4)
      for (int k = 0; k < 4; k++) check($sformatf("rr_grant%0d", k), grants[k], k % 2);
    check("rr_rsp0_count", r0.size(), 4);
    check("rr_rsp1_count", r1.size(), 3);
    if (r0.size() >= 2) check("rr_rsp0_period", r0[1] - r0[0], 4);
    if (r1.size() >= 2) check("rr_rsp1_period", r1[1] - r1[0], 4);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a store's ACCESS cycle
    we[0] = 1'b1; wd[0] = 3'd2; ad[0] = 32'h20; wdt[0] = 32'hDEAD_BEEF; v[0] = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rdy[0];
    end
    if (!got) fail_now("rst_store_accept_timeout");
    @(posedge clk); #1;
    v[0] = 1'b0;
    check("rst_pre_mem_we", {31'b0, mem_we}, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mem_we_drop", {31'b0, mem_we}, 0);
    @(negedge clk);
    check("rst_no_rsp", {31'b0, rsp0_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_rsp_after", {31'b0, rsp0_valid}, 0);
    @(posedge clk); #1;
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
    check("rst_readback", rd, 32'h0);

    // Randomized traffic from both ports, checked every cycle by the model
    fork
      rand_port(0, 150);
      rand_port(1, 150);
    join
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
